// File: rtl/alu_reservation_station_pkg.sv
// Shared constants for the ALU reservation station and the ALU opcode
// encodings used by the execute unit.
package alu_reservation_station_pkg;

    localparam int DATA_LEN     = 32;
    localparam int ALU_OP_WIDTH = 4;
    localparam int RRF_SEL      = 6;
    localparam int ENTRY_NUM    = 8;
    localparam int RS_ENT_SEL   = $clog2(ENTRY_NUM);

    typedef enum logic [ALU_OP_WIDTH-1:0] {
        ALU_OP_ADD  = 4'd0,
        ALU_OP_SUB  = 4'd1,
        ALU_OP_AND  = 4'd2,
        ALU_OP_OR   = 4'd3,
        ALU_OP_XOR  = 4'd4,
        ALU_OP_SLL  = 4'd5,
        ALU_OP_SRL  = 4'd6,
        ALU_OP_SRA  = 4'd7,
        ALU_OP_SLT  = 4'd8,
        ALU_OP_SLTU = 4'd9
    } alu_op_e;

endpackage

// File: rtl/alu_rs_select.sv
// Lowest-index priority encoder: request vector -> found flag + index.
// Used both for free-slot search and for issue selection.
module alu_rs_select
    import alu_reservation_station_pkg::*;
#(
    parameter int N   = ENTRY_NUM,
    parameter int SEL = $clog2(N)
) (
    input  logic [N-1:0]   i_req,
    output logic           o_found,
    output logic [SEL-1:0] o_sel
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        o_found = 1'b0;
        o_sel   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_found = 1'b1;
                o_sel   = SEL'(i);
            end
        end
    end

endmodule

// File: rtl/alu_reservation_station.sv
// ALU issue queue: buffers dispatched ops, captures pending operands from two
// writeback buses, and issues the lowest-index ready op each cycle through
// registered outputs.
// Dispatch handshake: an op is accepted on a rising edge where i_dp_valid and
// o_dp_ready are both high and i_flush is low; o_dp_ready reflects the
// current valid bits only, so a slot freed by issue is reusable next cycle.
module alu_reservation_station
#(
    parameter int ENTRY_NUM    = alu_reservation_station_pkg::ENTRY_NUM,
    parameter int DATA_LEN     = alu_reservation_station_pkg::DATA_LEN,
    parameter int ALU_OP_WIDTH = alu_reservation_station_pkg::ALU_OP_WIDTH,
    parameter int RRF_SEL      = alu_reservation_station_pkg::RRF_SEL
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_flush,
    input  logic                    i_dp_valid,
    output logic                    o_dp_ready,
    input  logic [ALU_OP_WIDTH-1:0] i_dp_alu_op,
    input  logic [DATA_LEN-1:0]     i_dp_src1,
    input  logic                    i_dp_src1_rdy,
    input  logic [DATA_LEN-1:0]     i_dp_src2,
    input  logic                    i_dp_src2_rdy,
    input  logic [RRF_SEL-1:0]      i_dp_rrftag,
    input  logic                    i_dp_wrrf,
    input  logic                    i_wb0_valid,
    input  logic [RRF_SEL-1:0]      i_wb0_tag,
    input  logic [DATA_LEN-1:0]     i_wb0_data,
    input  logic                    i_wb1_valid,
    input  logic [RRF_SEL-1:0]      i_wb1_tag,
    input  logic [DATA_LEN-1:0]     i_wb1_data,
    output logic                    o_issue,
    output logic [ALU_OP_WIDTH-1:0] o_alu_op,
    output logic [DATA_LEN-1:0]     o_src1,
    output logic [DATA_LEN-1:0]     o_src2,
    output logic [RRF_SEL-1:0]      o_rrftag,
    output logic                    o_wrrf
);

    localparam int SEL = $clog2(ENTRY_NUM);

    logic [ENTRY_NUM-1:0]    r_valid;
    logic [ENTRY_NUM-1:0]    r_rdy1;
    logic [ENTRY_NUM-1:0]    r_rdy2;
    logic [ENTRY_NUM-1:0]    r_wrrf;
    logic [ALU_OP_WIDTH-1:0] r_op   [ENTRY_NUM];
    logic [DATA_LEN-1:0]     r_src1 [ENTRY_NUM];
    logic [DATA_LEN-1:0]     r_src2 [ENTRY_NUM];
    logic [RRF_SEL-1:0]      r_tag  [ENTRY_NUM];

    logic                    w_free_found;
    logic [SEL-1:0]          w_free_sel;
    logic                    w_iss_found;
    logic [SEL-1:0]          w_iss_sel;
    logic                    w_dp_fire;
    logic [DATA_LEN-1:0]     w_dp_src1;
    logic [DATA_LEN-1:0]     w_dp_src2;
    logic                    w_dp_rdy1;
    logic                    w_dp_rdy2;

    // Only the low RRF_SEL bits of a pending operand hold its tag.
    function automatic logic tag_hit(input logic v, input logic [RRF_SEL-1:0] bus_tag,
                                     input logic [DATA_LEN-1:0] src);
        return v && (bus_tag == src[RRF_SEL-1:0]);
    endfunction

    alu_rs_select #(.N(ENTRY_NUM), .SEL(SEL)) u_free_sel (
        .i_req   (~r_valid),
        .o_found (w_free_found),
        .o_sel   (w_free_sel)
    );

    // Selection looks at registered state only, so a wakeup is seen next cycle.
    alu_rs_select #(.N(ENTRY_NUM), .SEL(SEL)) u_iss_sel (
        .i_req   (r_valid & r_rdy1 & r_rdy2),
        .o_found (w_iss_found),
        .o_sel   (w_iss_sel)
    );

    assign o_dp_ready = w_free_found;
    assign w_dp_fire  = i_dp_valid && w_free_found && !i_flush;

    // Dispatch bypass: capture an operand broadcast in the dispatch cycle itself.
    always_comb begin
        w_dp_src1 = i_dp_src1;
        w_dp_rdy1 = i_dp_src1_rdy;
        w_dp_src2 = i_dp_src2;
        w_dp_rdy2 = i_dp_src2_rdy;
        if (!i_dp_src1_rdy) begin
            if (tag_hit(i_wb0_valid, i_wb0_tag, i_dp_src1)) begin
                w_dp_src1 = i_wb0_data;
                w_dp_rdy1 = 1'b1;
            end else if (tag_hit(i_wb1_valid, i_wb1_tag, i_dp_src1)) begin
                w_dp_src1 = i_wb1_data;
                w_dp_rdy1 = 1'b1;
            end
        end
        if (!i_dp_src2_rdy) begin
            if (tag_hit(i_wb0_valid, i_wb0_tag, i_dp_src2)) begin
                w_dp_src2 = i_wb0_data;
                w_dp_rdy2 = 1'b1;
            end else if (tag_hit(i_wb1_valid, i_wb1_tag, i_dp_src2)) begin
                w_dp_src2 = i_wb1_data;
                w_dp_rdy2 = 1'b1;
            end
        end
    end

    // Entry occupancy: set on dispatch, cleared on issue, wiped by reset/flush.
    always_ff @(posedge clk) begin
        if (reset || i_flush) begin
            r_valid <= '0;
        end else begin
            for (int i = 0; i < ENTRY_NUM; i++) begin
                if (w_dp_fire && (w_free_sel == SEL'(i))) begin
                    r_valid[i] <= 1'b1;
                end else if (w_iss_found && (w_iss_sel == SEL'(i))) begin
                    r_valid[i] <= 1'b0;
                end
            end
        end
    end

    // Entry payload: written on dispatch, operands filled in by writeback snoop.
    always_ff @(posedge clk) begin
        for (int i = 0; i < ENTRY_NUM; i++) begin
            if (w_dp_fire && (w_free_sel == SEL'(i))) begin
                r_op[i]   <= i_dp_alu_op;
                r_src1[i] <= w_dp_src1;
                r_rdy1[i] <= w_dp_rdy1;
                r_src2[i] <= w_dp_src2;
                r_rdy2[i] <= w_dp_rdy2;
                r_tag[i]  <= i_dp_rrftag;
                r_wrrf[i] <= i_dp_wrrf;
            end else if (r_valid[i]) begin
                if (!r_rdy1[i]) begin
                    if (tag_hit(i_wb0_valid, i_wb0_tag, r_src1[i])) begin
                        r_src1[i] <= i_wb0_data;
                        r_rdy1[i] <= 1'b1;
                    end else if (tag_hit(i_wb1_valid, i_wb1_tag, r_src1[i])) begin
                        r_src1[i] <= i_wb1_data;
                        r_rdy1[i] <= 1'b1;
                    end
                end
                if (!r_rdy2[i]) begin
                    if (tag_hit(i_wb0_valid, i_wb0_tag, r_src2[i])) begin
                        r_src2[i] <= i_wb0_data;
                        r_rdy2[i] <= 1'b1;
                    end else if (tag_hit(i_wb1_valid, i_wb1_tag, r_src2[i])) begin
                        r_src2[i] <= i_wb1_data;
                        r_rdy2[i] <= 1'b1;
                    end
                end
            end
        end
    end

    // Issue registers: pulse o_issue for the selected entry, hold data otherwise.
    always_ff @(posedge clk) begin
        if (reset || i_flush) begin
            o_issue  <= 1'b0;
            o_alu_op <= '0;
            o_src1   <= '0;
            o_src2   <= '0;
            o_rrftag <= '0;
            o_wrrf   <= 1'b0;
        end else if (w_iss_found) begin
            o_issue  <= 1'b1;
            o_alu_op <= r_op[w_iss_sel];
            o_src1   <= r_src1[w_iss_sel];
            o_src2   <= r_src2[w_iss_sel];
            o_rrftag <= r_tag[w_iss_sel];
            o_wrrf   <= r_wrrf[w_iss_sel];
        end else begin
            o_issue <= 1'b0;
        end
    end

endmodule
